// File: rtl/pe_feeder.sv
// pe_feeder: sequences operand-buffer reads into a PE, adds a bias and hands back the result
module pe_feeder #(
   parameter int LEN_W   = 8,
   parameter int ADDR_W  = 10,
   parameter int PE_LAT  = 6,
   parameter int ACC_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic [ADDR_W-1:0] w_base,
   input  logic [ADDR_W-1:0] x_base,
   input  logic [31:0]       bias,
   output logic              busy,
   output logic              w_rd_en,
   output logic              x_rd_en,
   output logic [ADDR_W-1:0] w_rd_addr,
   output logic [ADDR_W-1:0] x_rd_addr,
   input  logic [127:0]      w_rd_data,
   input  logic [127:0]      x_rd_data,
   output logic              pe_clr,
   output logic              pe_vld,
   output logic [127:0]      pe_a,
   output logic [127:0]      pe_b,
   output logic              pe_bias_add,
   output logic [31:0]       pe_bias_val,
   input  logic [31:0]       pe_out,
   output logic [31:0]       res_data,
   output logic              res_vld,
   input  logic              res_rdy
);
   localparam int CW = (LEN_W > $clog2(PE_LAT + ACC_LAT + 2)) ? LEN_W : $clog2(PE_LAT + ACC_LAT + 2);
   typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DRAIN, BIAS, BWAIT, OUT} state_t;
   state_t            state, state_nxt;
   logic [CW-1:0]     cnt, cnt_nxt;
   logic [LEN_W-1:0]  len_q;
   logic [ADDR_W-1:0] w_base_q, x_base_q;
   logic [31:0]       bias_q;
   logic              fetch;
   // next-state, shared phase counter and all state-decoded outputs
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      unique case (state)
         IDLE:    if (start) begin state_nxt = CLEAR; cnt_nxt = '0; end
         CLEAR:   begin state_nxt = (len_q != '0) ? FETCH : BIAS; cnt_nxt = '0; end
         FETCH:   if (cnt + CW'(1) == CW'(len_q)) begin state_nxt = DRAIN; cnt_nxt = '0; end
                  else cnt_nxt = cnt + CW'(1);
         DRAIN:   if (cnt == CW'(PE_LAT)) begin state_nxt = BIAS; cnt_nxt = '0; end
                  else cnt_nxt = cnt + CW'(1);
         BIAS:    begin state_nxt = BWAIT; cnt_nxt = '0; end
         BWAIT:   if (cnt == CW'(ACC_LAT - 1)) begin state_nxt = OUT; cnt_nxt = '0; end
                  else cnt_nxt = cnt + CW'(1);
         OUT:     if (res_rdy) state_nxt = IDLE;
         default: begin state_nxt = IDLE; cnt_nxt = '0; end
      endcase
      fetch       = state == FETCH;
      busy        = state != IDLE;
      w_rd_en     = fetch;
      x_rd_en     = fetch;
      w_rd_addr   = fetch ? w_base_q + ADDR_W'(cnt) : '0;
      x_rd_addr   = fetch ? x_base_q + ADDR_W'(cnt) : '0;
      pe_clr      = state == CLEAR;
      pe_bias_add = state == BIAS;
      pe_bias_val = (state == BIAS) ? bias_q : '0;
      res_vld     = state == OUT;
      pe_a        = pe_vld ? w_rd_data : '0;
      pe_b        = pe_vld ? x_rd_data : '0;
   end
   // state, job latches, read-data valid delay and result capture
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         len_q    <= '0;
         w_base_q <= '0;
         x_base_q <= '0;
         bias_q   <= '0;
         pe_vld   <= 1'b0;
         res_data <= '0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         pe_vld <= fetch;
         if (state == IDLE && start) begin
            len_q    <= len;
            w_base_q <= w_base;
            x_base_q <= x_base;
            bias_q   <= bias;
         end
         if (state == BWAIT && state_nxt == OUT) res_data <= pe_out;
      end
   end
endmodule
